// File: rtl/int_rr_arbiter.sv
// Round-robin arbiter sharing one internal register interface among NUM_MASTERS requesters.
// Optional WAIT-state timeout is compiled in with INT_ARB_TIMEOUT_EN.
module int_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wr_data,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_wr_strb,
  input  logic [NUM_MASTERS-1:0]               m_wr_en,
  input  logic [NUM_MASTERS-1:0]               m_rd_en,
  output logic [NUM_MASTERS-1:0]               m_wr_ack,
  output logic [NUM_MASTERS-1:0]               m_wr_err,
  output logic [NUM_MASTERS-1:0]               m_rd_ack,
  output logic [NUM_MASTERS-1:0]               m_rd_err,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_rd_data,
  output logic [ADDR_WIDTH-1:0]                int_addr,
  output logic [DATA_WIDTH-1:0]                int_wr_data,
  output logic [DATA_WIDTH/8-1:0]              int_wr_strb,
  output logic                                 int_wr_en,
  output logic                                 int_rd_en,
  input  logic                                 int_wr_ack,
  input  logic                                 int_wr_err,
  input  logic                                 int_rd_ack,
  input  logic                                 int_rd_err,
  input  logic [DATA_WIDTH-1:0]                int_rd_data,
  output logic [$clog2(NUM_MASTERS)-1:0]       grant_idx
);

  localparam int IDXW  = $clog2(NUM_MASTERS);
  localparam int STRBW = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                                   state_q, state_d;
  logic [IDXW-1:0]                          grant_q, grant_d;
  logic [IDXW-1:0]                          ptr_q, ptr_d;
  logic                                     wr_q, wr_d;
  logic [NUM_MASTERS-1:0]                   pending_q, pending_d;
  logic [NUM_MASTERS-1:0]                   slot_wr_q, slot_wr_d;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   slot_addr_q, slot_addr_d;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   slot_data_q, slot_data_d;
  logic [NUM_MASTERS-1:0][STRBW-1:0]        slot_strb_q, slot_strb_d;
  logic [ADDR_WIDTH-1:0]                    int_addr_q, int_addr_d;
  logic [DATA_WIDTH-1:0]                    int_wr_data_q, int_wr_data_d;
  logic [STRBW-1:0]                         int_wr_strb_q, int_wr_strb_d;
  logic                                     int_wr_en_q, int_wr_en_d;
  logic                                     int_rd_en_q, int_rd_en_d;
  logic [NUM_MASTERS-1:0]                   m_wr_ack_q, m_wr_ack_d;
  logic [NUM_MASTERS-1:0]                   m_wr_err_q, m_wr_err_d;
  logic [NUM_MASTERS-1:0]                   m_rd_ack_q, m_rd_ack_d;
  logic [NUM_MASTERS-1:0]                   m_rd_err_q, m_rd_err_d;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rd_data_q, m_rd_data_d;
  logic                                     win_vld;
  logic [IDXW-1:0]                          win_idx;
  logic [IDXW-1:0]                          cand;
  logic                                     ack_match;

`ifdef INT_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Search starts at ptr_q, which is one past the last grant (0 after reset).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NUM_MASTERS);
      if (!win_vld && pending_q[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign ack_match = wr_q ? int_wr_ack : int_rd_ack;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    wr_d          = wr_q;
    pending_d     = pending_q;
    slot_wr_d     = slot_wr_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    slot_strb_d   = slot_strb_q;
    int_addr_d    = int_addr_q;
    int_wr_data_d = int_wr_data_q;
    int_wr_strb_d = int_wr_strb_q;
    int_wr_en_d   = 1'b0;
    int_rd_en_d   = 1'b0;
    m_wr_ack_d    = '0;
    m_wr_err_d    = '0;
    m_rd_ack_d    = '0;
    m_rd_err_d    = '0;
    m_rd_data_d   = m_rd_data_q;
`ifdef INT_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          int_addr_d         = slot_addr_q[win_idx];
          int_wr_data_d      = slot_data_q[win_idx];
          int_wr_strb_d      = slot_strb_q[win_idx];
          int_wr_en_d        = slot_wr_q[win_idx];
          int_rd_en_d        = !slot_wr_q[win_idx];
          wr_d               = slot_wr_q[win_idx];
          pending_d[win_idx] = 1'b0;
          grant_d            = win_idx;
          ptr_d              = (win_idx == IDXW'(NUM_MASTERS - 1)) ? '0 : win_idx + IDXW'(1);
          state_d            = S_WAIT;
`ifdef INT_ARB_TIMEOUT_EN
          cnt_d              = '0;
`endif
        end
      end
      S_WAIT: begin
        if (ack_match) begin
          if (wr_q) begin
            m_wr_ack_d[grant_q] = 1'b1;
            m_wr_err_d[grant_q] = int_wr_err;
          end else begin
            m_rd_ack_d[grant_q]  = 1'b1;
            m_rd_err_d[grant_q]  = int_rd_err;
            m_rd_data_d[grant_q] = int_rd_data;
          end
          state_d = S_IDLE;
        end
`ifdef INT_ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          // Downstream never answered: fail the master, any late ack lands in IDLE.
          if (wr_q) begin
            m_wr_ack_d[grant_q] = 1'b1;
            m_wr_err_d[grant_q] = 1'b1;
          end else begin
            m_rd_ack_d[grant_q]  = 1'b1;
            m_rd_err_d[grant_q]  = 1'b1;
            m_rd_data_d[grant_q] = '0;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Capture runs after arbitration; the winner's own pulse is blocked by pending_q.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((m_wr_en[i] || m_rd_en[i]) && !pending_q[i] &&
          !(state_q == S_WAIT && grant_q == IDXW'(i))) begin
        pending_d[i]   = 1'b1;
        slot_wr_d[i]   = m_wr_en[i];
        slot_addr_d[i] = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_data_d[i] = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        slot_strb_d[i] = m_wr_strb[i*STRBW +: STRBW];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      wr_q          <= 1'b0;
      pending_q     <= '0;
      slot_wr_q     <= '0;
      slot_addr_q   <= '0;
      slot_data_q   <= '0;
      slot_strb_q   <= '0;
      int_addr_q    <= '0;
      int_wr_data_q <= '0;
      int_wr_strb_q <= '0;
      int_wr_en_q   <= 1'b0;
      int_rd_en_q   <= 1'b0;
      m_wr_ack_q    <= '0;
      m_wr_err_q    <= '0;
      m_rd_ack_q    <= '0;
      m_rd_err_q    <= '0;
      m_rd_data_q   <= '0;
`ifdef INT_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      wr_q          <= wr_d;
      pending_q     <= pending_d;
      slot_wr_q     <= slot_wr_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      slot_strb_q   <= slot_strb_d;
      int_addr_q    <= int_addr_d;
      int_wr_data_q <= int_wr_data_d;
      int_wr_strb_q <= int_wr_strb_d;
      int_wr_en_q   <= int_wr_en_d;
      int_rd_en_q   <= int_rd_en_d;
      m_wr_ack_q    <= m_wr_ack_d;
      m_wr_err_q    <= m_wr_err_d;
      m_rd_ack_q    <= m_rd_ack_d;
      m_rd_err_q    <= m_rd_err_d;
      m_rd_data_q   <= m_rd_data_d;
`ifdef INT_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign int_addr    = int_addr_q;
  assign int_wr_data = int_wr_data_q;
  assign int_wr_strb = int_wr_strb_q;
  assign int_wr_en   = int_wr_en_q;
  assign int_rd_en   = int_rd_en_q;
  assign m_wr_ack    = m_wr_ack_q;
  assign m_wr_err    = m_wr_err_q;
  assign m_rd_ack    = m_rd_ack_q;
  assign m_rd_err    = m_rd_err_q;
  assign m_rd_data   = m_rd_data_q;
  assign grant_idx   = grant_q;

endmodule

// File: tb/tb_int_rr_arbiter.sv
// Bench for int_rr_arbiter with four masters; expected downstream and ack
// events are queued with the stimulus and matched as the DUT produces them.
module tb_int_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic              aclk, aresetn;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wr_data;
  logic [N*SW-1:0]   m_wr_strb;
  logic [N-1:0]      m_wr_en, m_rd_en;
  logic [N-1:0]      m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
  logic [N*DW-1:0]   m_rd_data;
  logic [AW-1:0]     int_addr;
  logic [DW-1:0]     int_wr_data;
  logic [SW-1:0]     int_wr_strb;
  logic              int_wr_en, int_rd_en;
  logic              int_wr_ack, int_wr_err, int_rd_ack, int_rd_err;
  logic [DW-1:0]     int_rd_data;
  logic [1:0]        grant_idx;
  logic              auto_ack, man_wr_ack, man_rd_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         wr;
    logic [9:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [1:0] master;
  } dn_t;
  typedef struct {
    logic [1:0]  master;
    bit          wr;
    bit          err;
    logic [31:0] data;
  } ack_t;

  dn_t  dn_q[$];
  ack_t ack_q[$];
  dn_t  de;
  ack_t ae;

  int_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
    .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_wr_ack(m_wr_ack), .m_wr_err(m_wr_err), .m_rd_ack(m_rd_ack), .m_rd_err(m_rd_err),
    .m_rd_data(m_rd_data),
    .int_addr(int_addr), .int_wr_data(int_wr_data), .int_wr_strb(int_wr_strb),
    .int_wr_en(int_wr_en), .int_rd_en(int_rd_en),
    .int_wr_ack(int_wr_ack), .int_wr_err(int_wr_err),
    .int_rd_ack(int_rd_ack), .int_rd_err(int_rd_err), .int_rd_data(int_rd_data),
    .grant_idx(grant_idx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Auto mode answers every downstream pulse in the same cycle with err=0.
  always_comb begin
    int_wr_ack = auto_ack ? int_wr_en : man_wr_ack;
    int_rd_ack = auto_ack ? int_rd_en : man_rd_ack;
  end

  always @(negedge aclk) begin
    if (int_wr_en || int_rd_en) begin
      checks++;
      if (dn_q.size() == 0) begin
        errors++;
        $display("FAIL dn_unexpected wr_en=%0b rd_en=%0b addr=%h grant=%0d, required no downstream pulse",
                 int_wr_en, int_rd_en, int_addr, grant_idx);
      end else begin
        de = dn_q.pop_front();
        if (int_wr_en !== de.wr || int_rd_en !== !de.wr || int_addr !== de.addr ||
            grant_idx !== de.master ||
            (de.wr && (int_wr_data !== de.data || int_wr_strb !== de.strb))) begin
          errors++;
          $display("FAIL dn_txn got wr=%0b rd=%0b addr=%h data=%h strb=%h grant=%0d, required wr=%0b addr=%h data=%h strb=%h grant=%0d",
                   int_wr_en, int_rd_en, int_addr, int_wr_data, int_wr_strb, grant_idx,
                   de.wr, de.addr, de.data, de.strb, de.master);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_wr_ack[i] || m_rd_ack[i]) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected master=%0d wr_ack=%0b rd_ack=%0b, required no ack", i, m_wr_ack[i], m_rd_ack[i]);
        end else begin
          ae = ack_q.pop_front();
          if (ae.master !== 2'(i) || m_wr_ack[i] !== ae.wr || m_rd_ack[i] !== !ae.wr ||
              (ae.wr ? m_wr_err[i] : m_rd_err[i]) !== ae.err ||
              (!ae.wr && m_rd_data[i*DW +: DW] !== ae.data)) begin
            errors++;
            $display("FAIL ack_txn got master=%0d wr=%0b rd=%0b werr=%0b rerr=%0b data=%h, required master=%0d wr=%0b err=%0b data=%h",
                     i, m_wr_ack[i], m_rd_ack[i], m_wr_err[i], m_rd_err[i], m_rd_data[i*DW +: DW],
                     ae.master, ae.wr, ae.err, ae.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_req(input int m, input bit wr, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    m_addr[m*AW +: AW]    = a;
    m_wr_data[m*DW +: DW] = d;
    m_wr_strb[m*SW +: SW] = s;
    if (wr) m_wr_en[m] = 1'b1;
    else    m_rd_en[m] = 1'b1;
  endtask

  task automatic clear_req();
    m_wr_en = '0;
    m_rd_en = '0;
  endtask

  task automatic exp_dn(input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] m);
    dn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.strb = s; t.master = m;
    dn_q.push_back(t);
  endtask

  task automatic exp_ack(input logic [1:0] m, input bit wr, input bit err, input logic [31:0] d);
    ack_t t;
    t.master = m; t.wr = wr; t.err = err; t.data = d;
    ack_q.push_back(t);
  endtask

  task automatic test_reset();
    aresetn = 1'b0; auto_ack = 1'b0; man_wr_ack = 1'b0; man_rd_ack = 1'b0;
    int_wr_err = 1'b0; int_rd_err = 1'b0; int_rd_data = '0;
    m_addr = '0; m_wr_data = '0; m_wr_strb = '0; clear_req();
    step(); step();
    checks++;
    if ({int_wr_en, int_rd_en, m_wr_ack, m_rd_ack, m_wr_err, m_rd_err} !== '0) begin
      errors++;
      $display("FAIL reset_pulses got en=%0b%0b wack=%b rack=%b werr=%b rerr=%b, required all 0",
               int_wr_en, int_rd_en, m_wr_ack, m_rd_ack, m_wr_err, m_rd_err);
    end
    checks++;
    if (int_addr !== '0 || int_wr_data !== '0 || int_wr_strb !== '0 || m_rd_data !== '0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h strb=%h rdata=%h grant=%0d, required all 0",
               int_addr, int_wr_data, int_wr_strb, m_rd_data, grant_idx);
    end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    drive_req(1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    exp_dn(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 2'd1);
    step(); clear_req();
    checks++;
    if (int_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_t1 got %0b required 0", int_wr_en); end
    step();
    checks++;
    if (int_wr_en !== 1'b1 || grant_idx !== 2'd1) begin
      errors++; $display("FAIL wr_en_t2 got en=%0b grant=%0d required en=1 grant=1", int_wr_en, grant_idx);
    end
    step();
    checks++;
    if (int_wr_en !== 1'b0 || m_wr_ack !== '0 || int_addr !== 10'h010) begin
      errors++; $display("FAIL wr_t3 got en=%0b wack=%b addr=%h required 0 0000 010", int_wr_en, m_wr_ack, int_addr);
    end
    step();
    man_wr_ack = 1'b1; int_wr_err = 1'b0;
    exp_ack(2'd1, 1'b1, 1'b0, 32'h0);
    step(); man_wr_ack = 1'b0;
    checks++;
    if (m_wr_ack !== 4'b0010 || m_wr_err !== 4'b0000) begin
      errors++; $display("FAIL wr_ack_t5 got ack=%b err=%b required 0010 0000", m_wr_ack, m_wr_err);
    end
    step();
    checks++;
    if (m_wr_ack !== 4'b0000) begin errors++; $display("FAIL wr_ack_t6 got %b required 0000", m_wr_ack); end
  endtask

  task automatic test_read_same_cycle();
    drive_req(0, 1'b0, 10'h020, 32'h0, 4'h0);
    exp_dn(1'b0, 10'h020, 32'h0, 4'h0, 2'd0);
    step(); clear_req();
    step();
    checks++;
    if (int_rd_en !== 1'b1) begin errors++; $display("FAIL rd_en_t2 got %0b required 1", int_rd_en); end
    man_rd_ack = 1'b1; int_rd_data = 32'h12345678; int_rd_err = 1'b1;
    exp_ack(2'd0, 1'b0, 1'b1, 32'h12345678);
    step(); man_rd_ack = 1'b0; int_rd_err = 1'b0; int_rd_data = 32'h0;
    checks++;
    if (m_rd_ack !== 4'b0001 || m_rd_err[0] !== 1'b1 || m_rd_data[31:0] !== 32'h12345678) begin
      errors++; $display("FAIL rd_same_cycle got ack=%b err=%b data=%h required 0001 1 12345678",
                         m_rd_ack, m_rd_err, m_rd_data[31:0]);
    end
    step();
    checks++;
    if (m_rd_ack !== 4'b0000 || m_rd_data[31:0] !== 32'h12345678) begin
      errors++; $display("FAIL rd_hold got ack=%b data=%h required 0000 12345678", m_rd_ack, m_rd_data[31:0]);
    end
  endtask

  task automatic test_fairness();
    aresetn = 1'b0; step(); aresetn = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive_req(i, 1'b1, 10'(10'h100 + i), 32'(32'hA0 + i), 4'hF);
      exp_dn(1'b1, 10'(10'h100 + i), 32'(32'hA0 + i), 4'hF, 2'(i));
      exp_ack(2'(i), 1'b1, 1'b0, 32'h0);
    end
    step(); clear_req();
    repeat (10) step();
    drive_req(0, 1'b1, 10'h140, 32'hB0, 4'h1);
    drive_req(3, 1'b1, 10'h143, 32'hB3, 4'h8);
    exp_dn(1'b1, 10'h140, 32'hB0, 4'h1, 2'd0);
    exp_ack(2'd0, 1'b1, 1'b0, 32'h0);
    exp_dn(1'b1, 10'h143, 32'hB3, 4'h8, 2'd3);
    exp_ack(2'd3, 1'b1, 1'b0, 32'h0);
    step(); clear_req();
    repeat (8) step();
    auto_ack = 1'b0;
    checks++;
    if (grant_idx !== 2'd3 || dn_q.size() != 0 || ack_q.size() != 0) begin
      errors++; $display("FAIL fairness_drain got grant=%0d dn_left=%0d ack_left=%0d required 3 0 0",
                         grant_idx, dn_q.size(), ack_q.size());
    end
  endtask

  task automatic test_stray_acks();
    man_wr_ack = 1'b1;
    step(); man_wr_ack = 1'b0;
    step();
    checks++;
    if (grant_idx !== 2'd3 || m_wr_ack !== '0 || m_rd_ack !== '0 || int_wr_en !== 1'b0) begin
      errors++; $display("FAIL stray_idle got grant=%0d wack=%b rack=%b en=%0b required 3 0000 0000 0",
                         grant_idx, m_wr_ack, m_rd_ack, int_wr_en);
    end
    drive_req(2, 1'b1, 10'h0AA, 32'h55AA55AA, 4'h3);
    exp_dn(1'b1, 10'h0AA, 32'h55AA55AA, 4'h3, 2'd2);
    step(); clear_req();
    step();
    man_rd_ack = 1'b1; int_rd_err = 1'b1;
    step(); man_rd_ack = 1'b0; int_rd_err = 1'b0;
    checks++;
    if (m_wr_ack !== '0 || m_rd_ack !== '0) begin
      errors++; $display("FAIL wrong_type got wack=%b rack=%b required 0000 0000", m_wr_ack, m_rd_ack);
    end
    man_wr_ack = 1'b1;
    exp_ack(2'd2, 1'b1, 1'b0, 32'h0);
    step(); man_wr_ack = 1'b0;
    checks++;
    if (m_wr_ack !== 4'b0100) begin errors++; $display("FAIL after_wrong_type got %b required 0100", m_wr_ack); end
    step();
  endtask

  task automatic test_reset_mid();
    drive_req(0, 1'b1, 10'h0C0, 32'h0C0C0C0C, 4'hF);
    exp_dn(1'b1, 10'h0C0, 32'h0C0C0C0C, 4'hF, 2'd0);
    step(); clear_req();
    step();
    drive_req(2, 1'b1, 10'h0D0, 32'h0D0D0D0D, 4'hF);
    step(); clear_req();
    aresetn = 1'b0;
    step(); aresetn = 1'b1;
    checks++;
    if (grant_idx !== 2'd0 || int_wr_en !== 1'b0 || m_wr_ack !== '0) begin
      errors++; $display("FAIL reset_mid got grant=%0d en=%0b wack=%b required 0 0 0000", grant_idx, int_wr_en, m_wr_ack);
    end
    man_wr_ack = 1'b1;
    step(); man_wr_ack = 1'b0;
    repeat (4) step();
    drive_req(3, 1'b0, 10'h0E0, 32'h0, 4'h0);
    exp_dn(1'b0, 10'h0E0, 32'h0, 4'h0, 2'd3);
    step(); clear_req();
    step();
    checks++;
    if (int_rd_en !== 1'b1 || grant_idx !== 2'd3) begin
      errors++; $display("FAIL post_reset_grant got en=%0b grant=%0d required 1 3", int_rd_en, grant_idx);
    end
    man_rd_ack = 1'b1; int_rd_data = 32'hCAFEF00D;
    exp_ack(2'd3, 1'b0, 1'b0, 32'hCAFEF00D);
    step(); man_rd_ack = 1'b0; int_rd_data = 32'h0;
    checks++;
    if (m_rd_ack !== 4'b1000 || m_rd_data[127:96] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL post_reset_ack got ack=%b data=%h required 1000 cafef00d", m_rd_ack, m_rd_data[127:96]);
    end
    step();
  endtask

`ifdef INT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    lat = -1;
    drive_req(1, 1'b0, 10'h030, 32'h0, 4'h0);
    exp_dn(1'b0, 10'h030, 32'h0, 4'h0, 2'd1);
    exp_ack(2'd1, 1'b0, 1'b1, 32'h0);
    step(); clear_req();
    step();
    for (int c = 1; c <= 12; c++) begin
      step();
      if (m_rd_ack[1] === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 8 || m_rd_err[1] !== 1'b1 || m_rd_data[63:32] !== 32'h0) begin
      errors++; $display("FAIL timeout got latency=%0d err=%0b data=%h required 8 1 0", lat, m_rd_err[1], m_rd_data[63:32]);
    end
    step();
    man_rd_ack = 1'b1; int_rd_data = 32'h99;
    step(); man_rd_ack = 1'b0; int_rd_data = 32'h0;
    repeat (3) step();
    checks++;
    if (m_rd_data[63:32] !== 32'h0) begin
      errors++; $display("FAIL late_ack got data=%h required 0", m_rd_data[63:32]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_same_cycle();
    test_fairness();
    test_stray_acks();
    test_reset_mid();
`ifdef INT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) step();
    checks++;
    if (dn_q.size() != 0 || ack_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got dn_left=%0d ack_left=%0d required 0 0", dn_q.size(), ack_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_rr_arbiter.md
Name: int_rr_arbiter

Overview:
- Round-robin arbiter that shares one internal register interface (addr / wr_data / wr_strb / wr_en / rd_en pulses with ack / err / rd_data returns) among NUM_MASTERS requesters, e.g. several AXI4-Lite bridges or a local sequencer.
- Each requester sees a private internal-interface slave port. The downstream port drives the shared register file or decoder.
- Only one transaction is outstanding downstream at a time.

Parameters:
- NUM_MASTERS, 2, number of requester ports (2..8).
- ADDR_WIDTH, 10, internal address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with INT_ARB_TIMEOUT_EN.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address; master i uses slice i
- m_wr_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_wr_strb  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte strobes
- m_wr_en  in  NUM_MASTERS  per-master write request pulse
- m_rd_en  in  NUM_MASTERS  per-master read request pulse
- m_wr_ack  out  NUM_MASTERS  write-done pulse to master i
- m_wr_err  out  NUM_MASTERS  write error; valid with m_wr_ack
- m_rd_ack  out  NUM_MASTERS  read-done pulse to master i
- m_rd_err  out  NUM_MASTERS  read error; valid with m_rd_ack
- m_rd_data  out  NUM_MASTERS*DATA_WIDTH  read data; valid with m_rd_ack
- int_addr  out  ADDR_WIDTH  downstream address
- int_wr_data  out  DATA_WIDTH  downstream write data
- int_wr_strb  out  DATA_WIDTH/8  downstream strobes
- int_wr_en  out  1  downstream write pulse
- int_rd_en  out  1  downstream read pulse
- int_wr_ack, int_wr_err  in  1  downstream write response
- int_rd_ack, int_rd_err  in  1  downstream read response
- int_rd_data  in  DATA_WIDTH  downstream read data
- grant_idx  out  clog2(NUM_MASTERS)  index of last/current granted master (debug)

Behaviour:
- Interface protocol (both sides):
  - Requests are 1-cycle pulses with address and data valid in that cycle.
  - Exactly one ack per request, arriving in the same cycle as the en pulse or any later cycle.
  - A master issues no new request until its previous ack.
- Reset (aresetn=0 at a clock edge) clears:
  - all pending flags;
  - all outputs (pulses 0, data/addr/strb 0, err 0);
  - grant_idx=0 and the round-robin pointer (master 0 gets highest priority next);
  - state to IDLE.
  - A transaction in flight at reset is dropped, and no ack is returned for it.
- Capture: a request pulse on master i sets pending[i] and registers addr, data, strb and type in slot i.
  - If m_wr_en and m_rd_en are both high in one cycle, the write is kept and the read is dropped.
  - A pulse on master i while pending[i] is set, or while master i is granted, is ignored.
- FSM IDLE:
  - If any pending flag is set, select the first set index searching from (last_grant+1) mod NUM_MASTERS upward with wrap-around.
  - Then register the slot onto the int_* outputs, pulse int_wr_en or int_rd_en for one cycle, clear the winner's pending flag, update grant_idx, and go to WAIT.
  - Latency: request pulse in cycle T gives the downstream en pulse in T+2 when idle.
- FSM WAIT: an ack matching the issued type (int_wr_ack for a write, int_rd_ack for a read) is registered to the granted master in the next cycle as a 1-cycle m_*_ack, together with err and rd_data. The FSM then returns to IDLE.
  - A non-matching ack is ignored.
  - An ack in the same cycle as the en pulse is accepted.
- Acks arriving in IDLE are ignored.
- New requests are captured in every state, including the cycle the winner's pending flag clears.
- Minimum spacing between downstream en pulses is 2 cycles (en, then IDLE one cycle after the ack).
- int_addr, int_wr_data and int_wr_strb hold their value until the next grant.
- m_rd_data[i] holds its value until master i's next read ack.

Optional Feature:
- Macro: INT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without a matching ack, the granted master receives its ack pulse with err=1 (rd_data=0 for reads), and the FSM returns to IDLE.
  - A late downstream ack is then ignored.
- Undefined: WAIT holds indefinitely and no counter logic is present.

Test Plan:
- Single write: master 1 pulses wr addr 0x010 data 0xDEADBEEF strb 0xF at T -> int_wr_en at T+2 with the same fields; int_wr_ack err=0 at T+4 -> m_wr_ack[1]=1, m_wr_err[1]=0 at T+5 only.
- Read with same-cycle ack: master 0 reads addr 0x020; int_rd_ack with int_rd_data=0x12345678 and err=1 in the en cycle -> m_rd_ack[0] next cycle with data 0x12345678, m_rd_err[0]=1.
- Fairness: NUM_MASTERS=4, all four masters pulse a write in the same cycle, immediate acks -> grants in order 0,1,2,3; then masters 0 and 3 request again -> order 0,3.
- Wrong-type and stray acks: int_rd_ack during a write, and int_wr_ack in IDLE -> no m_* acks and the FSM is unchanged.
- Reset mid-operation: aresetn low for 1 cycle while in WAIT with master 2 pending -> no ack ever emitted; pending cleared; the next request from master 3 is granted first.
- Timeout (INT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): read never acked -> m_rd_ack with err=1 and data 0 after 8 WAIT cycles; a later int_rd_ack is ignored.
